uart_frame_parser: RTL and testbench
====================================

// Module: uart_frame_parser
// PURPOSE
// - Parametrised UART command-frame parser. It sits between the UART receiver and the MxV datapath.
// - Frame format: 0xFE, L, CMD, payload[0..P-1], [CHK], 0xEF.
// - It validates each frame and streams payload bytes, tagged with the command, to the FIFO/MxV loaders.
// - It reports frame_ok or frame_err with a cause code.
// - Successor of the fixed CMD4 controller: multi-command, N_MAX-sized, with timeout abort.
// PARAMETERS
// - DATA_W       8     UART byte width.
// - N_MAX        16    Max vector/row length accepted. LEN_W = $clog2(N_MAX+1).
// - TIMEOUT_CYC  50000 Idle clk cycles mid-frame before abort. 0 disables the timeout.
// PORTS
// - clk        in   1       Single clock; all logic on posedge.
// - rst        in   1       Synchronous reset, active-high.
// - rx_data    in   DATA_W  Received UART byte.
// - rx_valid   in   1       1-cycle strobe: rx_data valid.
// - n_cfg      in   LEN_W   Current matrix dimension N; sampled when 0xFE is accepted.
// - pay_data   out  DATA_W  Payload byte.
// - pay_valid  out  1       1-cycle strobe per payload byte.
// - pay_last   out  1       High with the final payload byte of a frame.
// - cmd_code   out  8       CMD of the frame in progress; held until the next CMD byte.
// - frame_ok   out  1       1-cycle pulse: frame fully valid.
// - frame_err  out  1       1-cycle pulse: frame aborted.
// - err_code   out  3       err_t cause; held until the next frame_err.
// - busy       out  1       High in every state except S_SOF.
// BEHAVIOUR
// Reset
// - rst=1 forces S_SOF. All outputs 0 and err_code=ERR_NONE on the next cycle; this holds mid-frame too.
// States
// - S_SOF: wait for rx_valid with 0xFE. Latch n_lat=n_cfg, then go to S_LEN. Any other byte is ignored.
// - S_LEN: latch L, then go to S_CMD.
// - S_CMD: exp = payload length for CMD:
//   - CMD_SIZE(1) -> 1.
//   - CMD_START(2) -> 0.
//   - CMD_ROW(3) -> n_lat.
//   - CMD_VEC(4) -> n_lat.
// - S_CMD errors:
//   - Unknown CMD -> ERR_CMD.
//   - exp > N_MAX, or L != exp+2 (+1 with CHK) -> ERR_LEN.
// - S_CMD success: load cmd_code. Go to S_PAY if exp>0, else to S_CHK or S_EOF.
// - S_PAY: each byte is forwarded. A down-counter stops at the exp-th byte, then the FSM moves on. 0xFE/0xEF bytes here are plain data.
// - S_EOF: 0xEF -> frame_ok. Anything else -> ERR_EOF. Both exits return to S_SOF.
// - Error exit: any error pulses frame_err, sets err_code and returns to S_SOF. The byte that caused the error is consumed, not re-parsed as SOF.
// Latency
// - pay_valid, pay_data and pay_last are registered, 1 cycle after the rx_valid of the byte.
// - frame_ok and frame_err are asserted 1 cycle after the deciding byte (or the timeout).
// Timeout
// - A counter clears on every rx_valid and counts while busy.
// - At TIMEOUT_CYC the frame aborts with ERR_TMO and the FSM returns to S_SOF.
// - If rx_valid arrives in the same cycle as the timeout, the byte wins and the count resets.
// Payload abort
// - Payload already emitted before an error is not retracted.
// - Consumers must discard on frame_err, which is delivered before any following pay_valid.
// Boundaries
// - n_cfg changes mid-frame have no effect; n_lat is used.
// - CMD_VEC/CMD_ROW with n_lat=0 is a zero-payload frame; pay_valid is never asserted.
// - rx_valid back-to-back on consecutive cycles must be accepted with no loss.
// CONFIGURATION
// - FRAME_CHECKSUM_EN defined:
//   - Adds state S_CHK between payload and EOF. Expected L becomes exp+3.
//   - CHK must equal XOR of L, CMD and all payload bytes; mismatch -> ERR_CHK.
// - FRAME_CHECKSUM_EN undefined:
//   - No S_CHK state; L = exp+2. ERR_CHK is never produced.
// STRUCTURE
// - mxv_pkg additions:
//   - SOF_BYTE=8'hFE, EOF_BYTE=8'hEF.
//   - CMD_SIZE=1, CMD_START=2, CMD_ROW=3, CMD_VEC=4.
//   - typedef enum logic[2:0] err_t {ERR_NONE, ERR_LEN, ERR_CMD, ERR_EOF, ERR_TMO, ERR_CHK}.
//   - typedef enum fsm_t {S_SOF, S_LEN, S_CMD, S_PAY, S_CHK, S_EOF}.
// - Sub-module: frame_timeout_counter (param TIMEOUT_CYC; ports clk, rst, clr, run, expired).
// - FSM, length check and payload counter stay in this module.
// TESTING
// - Case n_cfg=4, stream FE 06 04 11 22 33 44 EF:
//   - pay_valid x4 carrying 11,22,33,44. pay_last on 44. cmd_code=4.
//   - frame_ok 1 cycle after EF.
// - Case FE 06 09 ...: frame_err with err_code=ERR_CMD after byte 09. No pay_valid.
//   - Then send FE 03 01 07 EF: frame_ok with a single payload byte 07.
// - Case n_cfg=3, FE 06 04 ..: ERR_LEN at the CMD byte. Also L=05 with n_cfg=4 -> ERR_LEN.
// - Case FE 04 04 AA FE 55 (n_cfg=2):
//   - FE inside the payload is data; 55 triggers ERR_EOF.
// - Case stop after FE 06 04 11, wait TIMEOUT_CYC:
//   - frame_err with ERR_TMO; busy drops.
//   - rst asserted mid-payload: outputs 0 next cycle and a new frame parses.
// - Case FRAME_CHECKSUM_EN, FE 04 01 07 02 EF:
//   - 02 is correct (04^01^07) -> frame_ok.
//   - CHK 03 -> ERR_CHK.

Source files
------------

// File: rtl/uart_frame_parser_pkg.sv
// uart_frame_parser_pkg
// Shared constants and types for the UART command-frame parser:
//   - frame delimiters and command codes
//   - error cause codes (err_t) and parser states (fsm_t)
//   - FRAME_OVH: bytes counted by L besides the payload (CMD + EOF, plus CHK)
// Optional feature macro: FRAME_CHECKSUM_EN (adds the CHK byte to every frame).
package uart_frame_parser_pkg;

    localparam logic [7:0] SOF_BYTE  = 8'hFE;
    localparam logic [7:0] EOF_BYTE  = 8'hEF;

    localparam logic [7:0] CMD_SIZE  = 8'd1;
    localparam logic [7:0] CMD_START = 8'd2;
    localparam logic [7:0] CMD_ROW   = 8'd3;
    localparam logic [7:0] CMD_VEC   = 8'd4;

`ifdef FRAME_CHECKSUM_EN
    localparam int FRAME_OVH = 3;
`else
    localparam int FRAME_OVH = 2;
`endif

    typedef enum logic [2:0] {
        ERR_NONE = 3'd0,
        ERR_LEN  = 3'd1,
        ERR_CMD  = 3'd2,
        ERR_EOF  = 3'd3,
        ERR_TMO  = 3'd4,
        ERR_CHK  = 3'd5
    } err_t;

    typedef enum logic [2:0] {
        S_SOF = 3'd0,
        S_LEN = 3'd1,
        S_CMD = 3'd2,
        S_PAY = 3'd3,
        S_CHK = 3'd4,
        S_EOF = 3'd5
    } fsm_t;

endpackage

// File: rtl/uart_frame_parser_timeout.sv
// frame_timeout_counter
// Counts idle cycles while a frame is in progress and flags an abort.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   clr_i      a byte arrived this cycle: restart the idle count
//   run_i      parser is mid-frame (counting enabled)
//   expired_o  high in the TIMEOUT_CYC-th consecutive idle cycle
// TIMEOUT_CYC = 0 disables the timeout completely.
module frame_timeout_counter #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic run_i,
    output logic expired_o
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            assign expired_o = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
            logic [CW-1:0] cnt_q;

            // Idle-cycle counter; saturates at the abort threshold.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= {CW{1'b0}};
                end else if (clr_i || !run_i) begin
                    cnt_q <= {CW{1'b0}};
                end else if (cnt_q != CW'(TIMEOUT_CYC - 1)) begin
                    cnt_q <= cnt_q + CW'(1);
                end else begin
                    cnt_q <= cnt_q;
                end
            end

            // A byte in the threshold cycle wins over the abort.
            assign expired_o = run_i && !clr_i && (cnt_q == CW'(TIMEOUT_CYC - 1));
        end
    endgenerate

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
// Parses UART command frames  FE, L, CMD, payload[0..P-1], [CHK], EF
// and streams the payload bytes, tagged with the command, to the loaders.
// Ports:
//   clk_i        clock, all logic on posedge
//   rst_i        synchronous active-high reset
//   rx_data_i    received UART byte
//   rx_valid_i   1-cycle strobe qualifying rx_data_i
//   n_cfg_i      matrix dimension N, sampled when the SOF byte is accepted
//   pay_data_o   payload byte (registered)
//   pay_valid_o  1-cycle strobe per payload byte
//   pay_last_o   marks the final payload byte of a frame
//   cmd_code_o   CMD of the current frame, held until the next accepted CMD
//   frame_ok_o   1-cycle pulse: frame fully valid
//   frame_err_o  1-cycle pulse: frame aborted
//   err_code_o   cause of the last abort, held until the next one
//   busy_o       parser is inside a frame
// Optional feature macro: FRAME_CHECKSUM_EN adds a CHK byte (XOR of L, CMD
// and payload) between payload and EOF.
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter  int DATA_W      = 8,
    parameter  int N_MAX       = 16,
    parameter  int TIMEOUT_CYC = 50000,
    localparam int LEN_W       = $clog2(N_MAX + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    input  logic [LEN_W-1:0]  n_cfg_i,
    output logic [DATA_W-1:0] pay_data_o,
    output logic              pay_valid_o,
    output logic              pay_last_o,
    output logic [7:0]        cmd_code_o,
    output logic              frame_ok_o,
    output logic              frame_err_o,
    output err_t              err_code_o,
    output logic              busy_o
);

    fsm_t              state_q;
    logic [LEN_W-1:0]  n_lat_q;
    logic [DATA_W-1:0] len_q;
    logic [LEN_W-1:0]  rem_q;
    logic [DATA_W-1:0] pay_data_q;
    logic              pay_valid_q;
    logic              pay_last_q;
    logic [7:0]        cmd_code_q;
    logic              frame_ok_q;
    logic              frame_err_q;
    err_t              err_code_q;
`ifdef FRAME_CHECKSUM_EN
    logic [DATA_W-1:0] chk_q;
`endif

    logic              cmd_known_d;
    logic [LEN_W-1:0]  exp_d;
    logic              len_ok_d;
    logic              tmo_expired_s;

    assign busy_o = (state_q != S_SOF);

    frame_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (rx_valid_i),
        .run_i     (busy_o),
        .expired_o (tmo_expired_s)
    );

    // Decode the byte as a CMD: expected payload length and L consistency.
    always_comb begin
        cmd_known_d = 1'b1;
        exp_d       = {LEN_W{1'b0}};
        case (8'(rx_data_i))
            CMD_SIZE:         exp_d = LEN_W'(1);
            CMD_START:        exp_d = {LEN_W{1'b0}};
            CMD_ROW, CMD_VEC: exp_d = n_lat_q;
            default: begin
                cmd_known_d = 1'b0;
                exp_d       = {LEN_W{1'b0}};
            end
        endcase
        len_ok_d = (32'(exp_d) <= 32'(N_MAX)) &&
                   (32'(len_q) == 32'(exp_d) + 32'(FRAME_OVH));
    end

    // Frame FSM with registered payload stream and status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_SOF;
            n_lat_q     <= {LEN_W{1'b0}};
            len_q       <= {DATA_W{1'b0}};
            rem_q       <= {LEN_W{1'b0}};
            pay_data_q  <= {DATA_W{1'b0}};
            pay_valid_q <= 1'b0;
            pay_last_q  <= 1'b0;
            cmd_code_q  <= 8'd0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
`ifdef FRAME_CHECKSUM_EN
            chk_q       <= {DATA_W{1'b0}};
`endif
        end else begin
            pay_valid_q <= 1'b0;
            pay_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (tmo_expired_s) begin
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_TMO;
                state_q     <= S_SOF;
            end else if (rx_valid_i) begin
                case (state_q)
                    S_SOF: begin
                        if (rx_data_i == DATA_W'(SOF_BYTE)) begin
                            n_lat_q <= n_cfg_i;
                            state_q <= S_LEN;
                        end else begin
                            state_q <= S_SOF;
                        end
                    end
                    S_LEN: begin
                        len_q   <= rx_data_i;
`ifdef FRAME_CHECKSUM_EN
                        chk_q   <= rx_data_i;
`endif
                        state_q <= S_CMD;
                    end
                    S_CMD: begin
                        if (!cmd_known_d) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CMD;
                            state_q     <= S_SOF;
                        end else if (!len_ok_d) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_LEN;
                            state_q     <= S_SOF;
                        end else begin
                            cmd_code_q <= 8'(rx_data_i);
                            rem_q      <= exp_d;
`ifdef FRAME_CHECKSUM_EN
                            chk_q      <= chk_q ^ rx_data_i;
`endif
                            if (exp_d != {LEN_W{1'b0}}) begin
                                state_q <= S_PAY;
                            end else begin
`ifdef FRAME_CHECKSUM_EN
                                state_q <= S_CHK;
`else
                                state_q <= S_EOF;
`endif
                            end
                        end
                    end
                    S_PAY: begin
                        // Delimiter values are ordinary data while counting payload.
                        pay_data_q  <= rx_data_i;
                        pay_valid_q <= 1'b1;
                        rem_q       <= rem_q - LEN_W'(1);
`ifdef FRAME_CHECKSUM_EN
                        chk_q       <= chk_q ^ rx_data_i;
`endif
                        if (rem_q == LEN_W'(1)) begin
                            pay_last_q <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
                            state_q    <= S_CHK;
`else
                            state_q    <= S_EOF;
`endif
                        end else begin
                            state_q <= S_PAY;
                        end
                    end
`ifdef FRAME_CHECKSUM_EN
                    S_CHK: begin
                        if (rx_data_i == chk_q) begin
                            state_q <= S_EOF;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CHK;
                            state_q     <= S_SOF;
                        end
                    end
`endif
                    S_EOF: begin
                        if (rx_data_i == DATA_W'(EOF_BYTE)) begin
                            frame_ok_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_EOF;
                        end
                        state_q <= S_SOF;
                    end
                    default: begin
                        state_q <= S_SOF;
                    end
                endcase
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign pay_data_o  = pay_data_q;
    assign pay_valid_o = pay_valid_q;
    assign pay_last_o  = pay_last_q;
    assign cmd_code_o  = cmd_code_q;
    assign frame_ok_o  = frame_ok_q;
    assign frame_err_o = frame_err_q;
    assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed frames plus random
// frames, compared against a frame-level reference model.
module tb_uart_frame_parser;
    import uart_frame_parser_pkg::*;

    localparam int DW   = 8;
    localparam int NMAX = 16;
    localparam int TMO  = 40;
    localparam int LW   = $clog2(NMAX + 1);
`ifdef FRAME_CHECKSUM_EN
    localparam int OVH = 3;
`else
    localparam int OVH = 2;
`endif
    localparam logic [31:0] RES_OK   = 32'd100;
    localparam logic [31:0] RES_NONE = 32'd200;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [DW-1:0] rx_data_i = 8'h00;
    logic          rx_valid_i = 1'b0;
    logic [LW-1:0] n_cfg_i = '0;
    logic [DW-1:0] pay_data_o;
    logic          pay_valid_o;
    logic          pay_last_o;
    logic [7:0]    cmd_code_o;
    logic          frame_ok_o;
    logic          frame_err_o;
    logic [2:0]    err_code_o;
    logic          busy_o;

    uart_frame_parser #(
        .DATA_W      (DW),
        .N_MAX       (NMAX),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .n_cfg_i     (n_cfg_i),
        .pay_data_o  (pay_data_o),
        .pay_valid_o (pay_valid_o),
        .pay_last_o  (pay_last_o),
        .cmd_code_o  (cmd_code_o),
        .frame_ok_o  (frame_ok_o),
        .frame_err_o (frame_err_o),
        .err_code_o  (err_code_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; logic last; int st; } pay_t;
    typedef struct { logic [31:0] res; int st; } ev_t;

    pay_t       got_pay[$];
    ev_t        got_ev[$];
    int         neg_cnt = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    logic [7:0]  fr_q[$];
    logic [7:0]  m_pay[$];
    int          sent_st[$];
    logic [31:0] m_res;
    int          m_used;
    logic        m_cmd_ok;
    logic [7:0]  last_cmd = 8'd0;
    logic [31:0] last_err = 32'd0;
    logic [31:0] obs_res;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Output monitor: stamps every payload byte and frame verdict.
    always @(negedge clk) begin
        if (pay_valid_o) got_pay.push_back('{d: pay_data_o, last: pay_last_o, st: neg_cnt});
        if (frame_ok_o)  got_ev.push_back('{res: RES_OK, st: neg_cnt});
        if (frame_err_o) got_ev.push_back('{res: 32'(err_code_o), st: neg_cnt});
        neg_cnt <= neg_cnt + 1;
    end

    // Reference: parse the frame in fr_q as a whole, given N sampled at SOF.
    task automatic model(input int n);
        int   len, c, e, idx;
        logic bad_chk;
        logic [7:0] x;
        m_pay.delete();
        m_cmd_ok = 1'b0;
        bad_chk  = 1'b0;
        len = int'(fr_q[1]);
        c   = int'(fr_q[2]);
        if (c < 1 || c > 4) begin
            m_res = 32'(ERR_CMD); m_used = 3;
        end else begin
            e = (c == 1) ? 1 : ((c == 2) ? 0 : n);
            if (e > NMAX || len != e + OVH) begin
                m_res = 32'(ERR_LEN); m_used = 3;
            end else begin
                m_cmd_ok = 1'b1;
                for (int i = 0; i < e; i++) m_pay.push_back(fr_q[3 + i]);
                idx = 3 + e;
`ifdef FRAME_CHECKSUM_EN
                x = fr_q[1] ^ fr_q[2];
                foreach (m_pay[i]) x = x ^ m_pay[i];
                bad_chk = (fr_q[idx] != x);
                idx = idx + 1;
`else
                x = 8'h00;
`endif
                if (bad_chk) begin
                    m_res = 32'(ERR_CHK); m_used = idx;
                end else begin
                    m_res  = (fr_q[idx] == 8'hEF) ? RES_OK : 32'(ERR_EOF);
                    m_used = idx + 1;
                end
            end
        end
    endtask

    task automatic gen_frame(input int n);
        int c, e, r;
        logic [7:0] x;
        fr_q.delete();
        r = $urandom_range(0, 9);
        c = (r == 0) ? $urandom_range(5, 255) : ((r % 4) + 1);
        e = (c == 1) ? 1 : ((c == 2) ? 0 : ((c <= 4) ? n : 0));
        fr_q.push_back(8'hFE);
        fr_q.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(e + OVH));
        fr_q.push_back(8'(c));
        x = fr_q[1] ^ fr_q[2];
        for (int i = 0; i < e; i++) begin
            if ($urandom_range(0, 3) == 0) fr_q.push_back(($urandom_range(0, 1) == 0) ? 8'hFE : 8'hEF);
            else fr_q.push_back(8'($urandom));
            x = x ^ fr_q[3 + i];
        end
`ifdef FRAME_CHECKSUM_EN
        fr_q.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom) : x);
`endif
        fr_q.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hEF);
    endtask

    task automatic send_bytes(input int cnt, input int gmin, input int gmax);
        int gap;
        sent_st.delete();
        for (int i = 0; i < cnt; i++) begin
            gap = $urandom_range(gmax, gmin);
            repeat (gap) begin
                @(posedge clk); #1;
                rx_valid_i = 1'b0;
                rx_data_i  = 8'($urandom);
            end
            @(posedge clk); #1;
            rx_valid_i = 1'b1;
            rx_data_i  = fr_q[i];
            sent_st.push_back(neg_cnt);
            // N is latched at SOF; later changes must not matter.
            if (i == 1) n_cfg_i = LW'($urandom);
        end
    endtask

    task automatic compare_frame();
        int np;
        check_eq("pay_cnt", 32'(got_pay.size()), 32'(m_pay.size()));
        np = (got_pay.size() < m_pay.size()) ? got_pay.size() : m_pay.size();
        for (int i = 0; i < np; i++) begin
            check_eq("pay_data", 32'(got_pay[i].d), 32'(m_pay[i]));
            check_eq("pay_last", 32'(got_pay[i].last), 32'(i == m_pay.size() - 1));
            check_eq("pay_lat", 32'(got_pay[i].st), 32'(sent_st[3 + i] + 1));
        end
        check_eq("ev_cnt", 32'(got_ev.size()), 32'd1);
        obs_res = (got_ev.size() > 0) ? got_ev[0].res : RES_NONE;
        check_eq("result", obs_res, m_res);
        if (got_ev.size() > 0) check_eq("res_lat", 32'(got_ev[0].st), 32'(sent_st[m_used - 1] + 1));
        if (m_cmd_ok) last_cmd = fr_q[2];
        if (m_res != RES_OK) last_err = m_res;
        check_eq("cmd_code", 32'(cmd_code_o), 32'(last_cmd));
        check_eq("err_code", 32'(err_code_o), last_err);
        check_eq("busy_idle", 32'(busy_o), 32'd0);
        got_pay.delete();
        got_ev.delete();
    endtask

    task automatic run_frame(input int n, input int gmin, input int gmax);
        n_cfg_i = LW'(n);
        model(n);
        send_bytes(m_used, gmin, gmax);
        repeat (3) begin
            @(posedge clk); #1;
            rx_valid_i = 1'b0;
        end
        compare_frame();
    endtask

    task automatic set_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                             input logic [7:0] b6, input logic [7:0] b7);
        fr_q.delete();
        fr_q.push_back(b0); fr_q.push_back(b1); fr_q.push_back(b2); fr_q.push_back(b3);
        fr_q.push_back(b4); fr_q.push_back(b5); fr_q.push_back(b6); fr_q.push_back(b7);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_pay_valid", 32'(pay_valid_o), 32'd0);
        check_eq("rst_cmd", 32'(cmd_code_o), 32'd0);
        check_eq("rst_err", 32'(err_code_o), 32'(ERR_NONE));
        check_eq("rst_ok_err", 32'({frame_ok_o, frame_err_o}), 32'd0);
        rst_i = 1'b0;

`ifndef FRAME_CHECKSUM_EN
        set_frame(8'hFE, 8'h06, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hEF);
        run_frame(4, 0, 0);
        check_eq("d_vec_ok", obs_res, RES_OK);
        check_eq("d_vec_cmd", 32'(cmd_code_o), 32'd4);

        set_frame(8'hFE, 8'h06, 8'h09, 8'h11, 8'h22, 8'h33, 8'h44, 8'hEF);
        run_frame(4, 0, 0);
        check_eq("d_bad_cmd", obs_res, 32'(ERR_CMD));

        set_frame(8'hFE, 8'h03, 8'h01, 8'h07, 8'hEF, 8'h00, 8'h00, 8'h00);
        run_frame(4, 0, 0);
        check_eq("d_size_ok", obs_res, RES_OK);

        set_frame(8'hFE, 8'h06, 8'h04, 8'h11, 8'h22, 8'h33, 8'hEF, 8'h00);
        run_frame(3, 0, 0);
        check_eq("d_len_n3", obs_res, 32'(ERR_LEN));

        set_frame(8'hFE, 8'h05, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hEF);
        run_frame(4, 0, 0);
        check_eq("d_len_l5", obs_res, 32'(ERR_LEN));

        set_frame(8'hFE, 8'h04, 8'h04, 8'hAA, 8'hFE, 8'h55, 8'h00, 8'h00);
        run_frame(2, 0, 0);
        check_eq("d_eof", obs_res, 32'(ERR_EOF));

        set_frame(8'hFE, 8'h02, 8'h03, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00);
        run_frame(0, 0, 1);
        check_eq("d_row_n0", obs_res, RES_OK);
`else
        set_frame(8'hFE, 8'h04, 8'h01, 8'h07, 8'h02, 8'hEF, 8'h00, 8'h00);
        run_frame(4, 0, 0);
        check_eq("d_chk_ok", obs_res, RES_OK);

        set_frame(8'hFE, 8'h04, 8'h01, 8'h07, 8'h03, 8'hEF, 8'h00, 8'h00);
        run_frame(4, 0, 0);
        check_eq("d_chk_bad", obs_res, 32'(ERR_CHK));
`endif

        // Timeout: stall after the first payload byte.
        set_frame(8'hFE, 8'(4 + OVH), 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hEF);
        n_cfg_i = LW'(4);
        send_bytes(4, 0, 0);
        @(posedge clk); #1;
        rx_valid_i = 1'b0;
        for (int k = 0; k < TMO + 20 && got_ev.size() == 0; k++) begin
            @(posedge clk); #1;
        end
        check_eq("tmo_ev", 32'(got_ev.size()), 32'd1);
        if (got_ev.size() > 0) begin
            check_eq("tmo_code", got_ev[0].res, 32'(ERR_TMO));
            check_eq("tmo_lat", 32'(got_ev[0].st), 32'(sent_st[3] + 1 + TMO));
        end
        check_eq("tmo_pay", 32'(got_pay.size()), 32'd1);
        check_eq("tmo_busy", 32'(busy_o), 32'd0);
        got_pay.delete(); got_ev.delete();
        last_cmd = 8'h04; last_err = 32'(ERR_TMO);

        // Gaps of TMO-1 idle cycles: the byte arrives in the threshold cycle.
        fr_q.delete();
        fr_q.push_back(8'hFE); fr_q.push_back(8'(1 + OVH)); fr_q.push_back(8'h01);
        fr_q.push_back(8'h5A);
`ifdef FRAME_CHECKSUM_EN
        fr_q.push_back(8'(1 + OVH) ^ 8'h01 ^ 8'h5A);
`endif
        fr_q.push_back(8'hEF);
        run_frame(5, TMO - 1, TMO - 1);
        check_eq("d_gap_ok", obs_res, RES_OK);

        // Reset in the middle of a payload.
        set_frame(8'hFE, 8'(4 + OVH), 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hEF);
        n_cfg_i = LW'(4);
        send_bytes(4, 0, 0);
        @(posedge clk); #1;
        rx_valid_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk); #1;
        check_eq("mrst_busy", 32'(busy_o), 32'd0);
        check_eq("mrst_cmd", 32'(cmd_code_o), 32'd0);
        check_eq("mrst_err", 32'(err_code_o), 32'(ERR_NONE));
        check_eq("mrst_pulses", 32'({pay_valid_o, pay_last_o, frame_ok_o, frame_err_o}), 32'd0);
        check_eq("mrst_data", 32'(pay_data_o), 32'd0);
        rst_i = 1'b0;
        got_pay.delete(); got_ev.delete();
        last_cmd = 8'h00; last_err = 32'd0;
        fr_q.delete();
        fr_q.push_back(8'hFE); fr_q.push_back(8'(2 + OVH)); fr_q.push_back(8'h04);
        fr_q.push_back(8'hC3); fr_q.push_back(8'h3C);
`ifdef FRAME_CHECKSUM_EN
        fr_q.push_back(8'(2 + OVH) ^ 8'h04 ^ 8'hC3 ^ 8'h3C);
`endif
        fr_q.push_back(8'hEF);
        run_frame(2, 0, 0);
        check_eq("mrst_new_ok", obs_res, RES_OK);

        // Random frames, mostly back-to-back bytes.
        for (int f = 0; f < 150; f++) begin
            int n;
            n = $urandom_range(0, NMAX + 2);
            gen_frame(n);
            run_frame(n, 0, ($urandom_range(0, 3) == 0) ? 3 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
